// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter sharing one picorv32 native memory port.
// Round-robin or fixed priority, one transaction per grant, optional hang watchdog.
module picorv32_mem_arbiter #(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);
    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_GNT0 = 2'b01,
        S_GNT1 = 2'b10
    } state_t;

    localparam bit          WDOG_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_next;
    logic        r_last_owner;
    logic        w_last_owner_next;
    logic [15:0] r_wdog;
    logic [15:0] w_wdog_next;
    logic        w_in_gnt;
    logic        w_owner;
    logic        w_owner_valid;
    logic        w_timeout;

    assign w_in_gnt      = (r_state == S_GNT0) || (r_state == S_GNT1);
    assign w_owner       = (r_state == S_GNT1);
    assign w_owner_valid = w_owner ? m1_mem_valid : m0_mem_valid;
    // A slave ready in the final watchdog cycle wins over the forced completion.
    assign w_timeout     = WDOG_EN && w_in_gnt && w_owner_valid && !s_mem_ready
                           && (r_wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'b00;
            r_last_owner <= 1'b1;
            r_wdog       <= 16'd0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_owner <= w_last_owner_next;
            r_wdog       <= w_wdog_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_owner_next = r_last_owner;
        w_wdog_next       = r_wdog;
        case (r_state)
            S_IDLE: begin
                w_wdog_next = 16'd0;
                if (m0_mem_valid && m1_mem_valid) begin
                    if ((ROUND_ROBIN != 0) && !r_last_owner) w_state_next = S_GNT1;
                    else                                      w_state_next = S_GNT0;
                end else if (m0_mem_valid) begin
                    w_state_next = S_GNT0;
                end else if (m1_mem_valid) begin
                    w_state_next = S_GNT1;
                end
            end
            S_GNT0, S_GNT1: begin
                if (s_mem_ready || w_timeout) begin
                    w_state_next      = S_IDLE;
                    w_last_owner_next = w_owner;
                    w_wdog_next       = 16'd0;
                end else if (!w_owner_valid) begin
                    // Owner withdrew mid-transaction: release without a ready pulse.
                    w_state_next = S_IDLE;
                    w_wdog_next  = 16'd0;
                end else if (WDOG_EN) begin
                    w_wdog_next = r_wdog + 16'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        w_grant_next = {w_state_next == S_GNT1, w_state_next == S_GNT0};
    end

    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_addr   = 32'd0;
        s_mem_wdata  = 32'd0;
        s_mem_wstrb  = 4'd0;
        m0_mem_ready = 1'b0;
        m1_mem_ready = 1'b0;
        case (r_state)
            S_GNT0: begin
                s_mem_valid  = m0_mem_valid;
                s_mem_instr  = m0_mem_instr;
                s_mem_addr   = m0_mem_addr;
                s_mem_wdata  = m0_mem_wdata;
                s_mem_wstrb  = m0_mem_wstrb;
                m0_mem_ready = s_mem_ready || w_timeout;
            end
            S_GNT1: begin
                s_mem_valid  = m1_mem_valid;
                s_mem_instr  = m1_mem_instr;
                s_mem_addr   = m1_mem_addr;
                s_mem_wdata  = m1_mem_wdata;
                s_mem_wstrb  = m1_mem_wstrb;
                m1_mem_ready = s_mem_ready || w_timeout;
            end
            default: ;
        endcase
    end

    assign m0_mem_rdata = w_timeout ? 32'h0 : s_mem_rdata;
    assign m1_mem_rdata = w_timeout ? 32'h0 : s_mem_rdata;
    assign grant        = r_grant;
    assign timeout_err  = w_timeout;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: instance 0 is round-robin with an 8-cycle watchdog,
// instance 1 is fixed-priority without watchdog; each has its own slave memory model.
module tb_picorv32_mem_arbiter;
    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_to;
        int          exp_lat;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    // Requester k = 2*instance + master
    logic        m_valid [4];
    logic        m_instr [4];
    logic        m_ready [4];
    logic [31:0] m_addr  [4];
    logic [31:0] m_wdata [4];
    logic [31:0] m_rdata [4];
    logic [3:0]  m_wstrb [4];

    logic        s_valid [2];
    logic        s_instr [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [3:0]  s_wstrb [2];
    logic [1:0]  grant   [2];
    logic        tmo     [2];

    int          slv_lat  [2];
    logic        slv_hang [2];

    logic [31:0] ref_mem [2][256];
    txn_t        txn_q   [4][$];
    int          order_q [2][$];
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 255) return 32'h11;
        return {16'ha5a5, 8'(i), 8'(i ^ 32'hff)};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic        s_ready;
        logic [31:0] s_rdata;
        logic [31:0] mem [256];
        int          cnt;

        picorv32_mem_arbiter #(
            .ROUND_ROBIN    ((gi == 0) ? 1 : 0),
            .TIMEOUT_CYCLES ((gi == 0) ? 8 : 0)
        ) u_dut (
            .clk          (clk),
            .resetn       (resetn),
            .m0_mem_valid (m_valid[2*gi]),
            .m0_mem_instr (m_instr[2*gi]),
            .m0_mem_addr  (m_addr[2*gi]),
            .m0_mem_wdata (m_wdata[2*gi]),
            .m0_mem_wstrb (m_wstrb[2*gi]),
            .m0_mem_ready (m_ready[2*gi]),
            .m0_mem_rdata (m_rdata[2*gi]),
            .m1_mem_valid (m_valid[2*gi+1]),
            .m1_mem_instr (m_instr[2*gi+1]),
            .m1_mem_addr  (m_addr[2*gi+1]),
            .m1_mem_wdata (m_wdata[2*gi+1]),
            .m1_mem_wstrb (m_wstrb[2*gi+1]),
            .m1_mem_ready (m_ready[2*gi+1]),
            .m1_mem_rdata (m_rdata[2*gi+1]),
            .s_mem_valid  (s_valid[gi]),
            .s_mem_instr  (s_instr[gi]),
            .s_mem_addr   (s_addr[gi]),
            .s_mem_wdata  (s_wdata[gi]),
            .s_mem_wstrb  (s_wstrb[gi]),
            .s_mem_ready  (s_ready),
            .s_mem_rdata  (s_rdata),
            .grant        (grant[gi]),
            .timeout_err  (tmo[gi])
        );

        // Slave: answers slv_lat cycles after the request is first seen, or never when hung.
        always @(posedge clk) begin
            s_ready <= 1'b0;
            if (!resetn) begin
                cnt <= 0;
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            end else if (s_valid[gi] && !s_ready) begin
                if (!slv_hang[gi] && cnt == slv_lat[gi]) begin
                    s_ready <= 1'b1;
                    s_rdata <= mem[s_addr[gi][9:2]];
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[gi][b]) mem[s_addr[gi][9:2]][8*b +: 8] <= s_wdata[gi][8*b +: 8];
                    cnt <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end else if (!s_valid[gi]) begin
                cnt <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Queue a transaction with its expected result taken from the reference memory.
    task automatic q_txn(input int k, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic to, input int lat);
        txn_t t;
        int   inst;
        int   idx;
        inst        = k / 2;
        idx         = int'(addr[9:2]);
        t.instr     = instr;
        t.addr      = addr;
        t.wdata     = wdata;
        t.wstrb     = wstrb;
        t.exp_to    = to;
        t.exp_lat   = lat;
        t.exp_rdata = 32'h0;
        if (wstrb == 4'd0) begin
            if (!to) t.exp_rdata = ref_mem[inst][idx];
        end else begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) ref_mem[inst][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        txn_q[k].push_back(t);
    endtask

    // Present queued transactions back to back, holding valid until each ready.
    task automatic run_master(input int k);
        txn_t t;
        int   cyc;
        int   inst;
        int   j;
        logic had_prev;
        inst     = k / 2;
        j        = k % 2;
        had_prev = 1'b0;
        @(posedge clk); #1;
        while (txn_q[k].size() > 0) begin
            t          = txn_q[k][0];
            m_valid[k] = 1'b1;
            m_instr[k] = t.instr;
            m_addr[k]  = t.addr;
            m_wdata[k] = t.wdata;
            m_wstrb[k] = t.wstrb;
            cyc        = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (cyc == 1 && had_prev) chk("bubble", 32'(grant[inst]), 32'd0);
            end while (m_ready[k] !== 1'b1 && cyc < 64);
            if (m_ready[k] !== 1'b1) begin
                chk("ready_seen", 32'(m_ready[k]), 32'd1);
                txn_q[k].delete();
            end else begin
                chk("rdy_grant", 32'(grant[inst]), 32'(1 << j));
                chk("other_rdy", 32'(m_ready[k ^ 1]), 32'd0);
                if (t.wstrb == 4'd0) chk("rdata", m_rdata[k], t.exp_rdata);
                chk("timeout_err", 32'(tmo[inst]), 32'(t.exp_to));
                chk("s_addr", s_addr[inst], t.addr);
                chk("s_wdata", s_wdata[inst], t.wdata);
                chk("s_wstrb", 32'(s_wstrb[inst]), 32'(t.wstrb));
                chk("s_instr", 32'(s_instr[inst]), 32'(t.instr));
                if (t.exp_lat > 0) chk("latency", 32'(cyc), 32'(t.exp_lat));
                order_q[inst].push_back(j);
                $display("txn inst%0d m%0d addr=%08h wstrb=%b rdata=%08h tmo=%0b cycles=%0d",
                         inst, j, t.addr, t.wstrb, m_rdata[k], tmo[inst], cyc);
                void'(txn_q[k].pop_front());
            end
            had_prev = 1'b1;
            @(posedge clk); #1;
        end
        m_valid[k] = 1'b0;
    endtask

    // seq bit i is the master expected to complete the i-th transaction.
    task automatic check_order(input int inst, input int n, input logic [15:0] seq);
        chk("order_len", 32'(order_q[inst].size()), 32'(n));
        for (int i = 0; i < n && i < order_q[inst].size(); i++)
            chk("order", 32'(order_q[inst][i]), 32'(seq[i]));
        order_q[inst].delete();
    endtask

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_instr[k] = 1'b0;
            m_addr[k]  = 32'd0;
            m_wdata[k] = 32'd0;
            m_wstrb[k] = 4'd0;
        end
        for (int n = 0; n < 2; n++) begin
            slv_lat[n]  = 0;
            slv_hang[n] = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[n][i] = init_word(i);
        end
        repeat (3) @(negedge clk);
        chk("rst_grant0", 32'(grant[0]), 32'd0);
        chk("rst_grant1", 32'(grant[1]), 32'd0);
        chk("rst_svalid", 32'(s_valid[0]), 32'd0);
        chk("rst_saddr", s_addr[0], 32'd0);
        chk("rst_m0_ready", 32'(m_ready[0]), 32'd0);
        chk("rst_m1_ready", 32'(m_ready[1]), 32'd0);
        chk("rst_tmo", 32'(tmo[0]), 32'd0);
        resetn = 1'b1;

        // Round-robin contention: m0 first after reset, then strict alternation.
        for (int i = 0; i < 4; i++) begin
            q_txn(0, 1'b1, 32'h100 + 32'(4*i), 32'd0, 4'd0, 1'b0, 0);
            q_txn(1, 1'b0, 32'h200 + 32'(4*i), 32'd0, 4'd0, 1'b0, 0);
        end
        fork
            run_master(0);
            run_master(1);
        join
        check_order(0, 8, 16'h00aa);

        // Fixed priority: m1 waits until m0 stops requesting.
        for (int i = 0; i < 4; i++) q_txn(2, 1'b0, 32'h300 + 32'(4*i), 32'd0, 4'd0, 1'b0, 0);
        for (int i = 0; i < 2; i++) q_txn(3, 1'b0, 32'h080 + 32'(4*i), 32'd0, 4'd0, 1'b0, 0);
        fork
            run_master(2);
            run_master(3);
        join
        check_order(1, 6, 16'h0030);

        // Single read from idle.
        q_txn(0, 1'b0, 32'h3fc, 32'd0, 4'd0, 1'b0, 3);
        run_master(0);
        order_q[0].delete();

        // Partial write then read back.
        q_txn(1, 1'b0, 32'h10, 32'hdeadbeef, 4'b0011, 1'b0, 0);
        q_txn(1, 1'b0, 32'h10, 32'd0, 4'd0, 1'b0, 0);
        run_master(1);
        order_q[0].delete();

        // Hung slave: both requesters time out, m0 first.
        slv_hang[0] = 1'b1;
        q_txn(0, 1'b0, 32'h3fc, 32'd0, 4'd0, 1'b1, 9);
        q_txn(1, 1'b0, 32'h020, 32'd0, 4'd0, 1'b1, 0);
        fork
            run_master(0);
            run_master(1);
        join
        check_order(0, 2, 16'h0002);

        // Slave ready in the last watchdog cycle completes normally.
        slv_hang[0] = 1'b0;
        slv_lat[0]  = 6;
        q_txn(0, 1'b0, 32'h3fc, 32'd0, 4'd0, 1'b0, 9);
        run_master(0);
        order_q[0].delete();
        slv_lat[0]  = 0;

        // Asynchronous reset in the middle of a GNT1 cycle.
        slv_hang[0] = 1'b1;
        @(posedge clk); #1;
        m_valid[1] = 1'b1;
        m_addr[1]  = 32'h44;
        m_instr[1] = 1'b0;
        m_wstrb[1] = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_grant", 32'(grant[0]), 32'd2);
        chk("pre_rst_svalid", 32'(s_valid[0]), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant[0]), 32'd0);
        chk("async_rst_svalid", 32'(s_valid[0]), 32'd0);
        chk("async_rst_m1_ready", 32'(m_ready[1]), 32'd0);
        m_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn      = 1'b1;
        slv_hang[0] = 1'b0;
        q_txn(0, 1'b0, 32'h040, 32'd0, 4'd0, 1'b0, 0);
        q_txn(1, 1'b0, 32'h3fc, 32'd0, 4'd0, 1'b0, 0);
        fork
            run_master(0);
            run_master(1);
        join
        check_order(0, 2, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "global timeout");
    end
endmodule
